// File: rtl/ntt_pkg.sv
// Shared types and constants for the 4-point NTT (q = 7681) datapath and its front end.
package ntt_pkg;

    localparam int W        = 17;    // coefficient width at the core ports
    localparam int Q        = 7681;  // modulus
    localparam int CORE_LAT = 4;     // core input sample -> core output valid, in cycles

    // Twiddles of the 4-point negacyclic core: psi, psi^2 (the 4th root omega), psi^3.
    localparam int PSI   = 1925;
    localparam int OMEGA = 3383;
    localparam int PSI3  = 6468;

    typedef logic [W-1:0] coef_t;
    typedef coef_t [3:0]  coef_vec_t;  // element [0] sits in bits [W-1:0]

    typedef enum logic {
        TAG_A = 1'b0,
        TAG_B = 1'b1
    } tag_t;

    typedef struct packed {
        tag_t      tag;
        coef_vec_t data;
    } result_t;

    // True when any coefficient of the vector is not a reduced residue mod Q.
    function automatic logic any_out_of_range(input coef_vec_t v);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] >= coef_t'(Q)) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ntt4_core_arbiter_if.sv
// Requester and result handshakes of the shared NTT core front end.
// The slave modport is the arbiter side, the master modport the producer/consumer side.
interface ntt4_core_arbiter_if
    import ntt_pkg::*;
();

    logic      a_valid;
    logic      a_ready;
    coef_vec_t a_coef;

    logic      b_valid;
    logic      b_ready;
    coef_vec_t b_coef;

    logic      res_valid;
    logic      res_ready;
    logic      res_tag;
    coef_vec_t res_data;

    modport master (
        output a_valid, a_coef, b_valid, b_coef, res_ready,
        input  a_ready, b_ready, res_valid, res_tag, res_data
    );

    modport slave (
        input  a_valid, a_coef, b_valid, b_coef, res_ready,
        output a_ready, b_ready, res_valid, res_tag, res_data
    );

endinterface

// File: rtl/ntt_result_fifo.sv
// Synchronous FIFO holding tagged core results; exposes its occupancy for credit checks.
module ntt_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage write port.
    // NOTE: the array has no reset; entries are only observable once count says they were written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally modulo DEPTH; count tracks simultaneous push and pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/ntt4_core_arbiter.sv
// Round-robin front end sharing one free-running 4-point NTT core between requesters A and B.
// Issues are credit-limited so every transform in flight already owns a result FIFO slot.
module ntt4_core_arbiter
    import ntt_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    ntt4_core_arbiter_if.slave bus,
    output coef_vec_t         core_in,
    input  coef_vec_t         core_out,
    output logic              busy,
    output logic              range_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tag_t            rr_ptr;
    logic            grant_a;
    logic            grant_b;
    logic            issue;
    coef_vec_t       issue_coef;
    logic            can_issue;

    // Stage 0 lines up with the core_in register, stage CORE_LAT with core_out.
    logic [CORE_LAT:0] trk_vld;
    logic [CORE_LAT:0] trk_tag;

    logic [CW-1:0]   inflight_count;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     used;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    result_t         push_entry;
    result_t         head;

    // Number of transforms between the core_in register and core_out.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        inflight_count = '0;
        for (int i = 0; i <= CORE_LAT; i++) begin
            inflight_count = inflight_count + {{(CW-1){1'b0}}, trk_vld[i]};
        end
    end

    assign used      = {1'b0, fifo_count} + {1'b0, inflight_count};
    assign can_issue = used < (CW+1)'(FIFO_DEPTH);

    // Round-robin grant: a lone requester always wins, a tie goes to the pointer holder.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (can_issue) begin
            if (bus.a_valid && (!bus.b_valid || rr_ptr == TAG_A)) grant_a = 1'b1;
            else if (bus.b_valid)                                  grant_b = 1'b1;
        end
    end

    assign issue      = grant_a | grant_b;
    assign issue_coef = grant_b ? bus.b_coef : bus.a_coef;
    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;

    // Issue register: drives the core, moves the RR pointer and latches the range flag.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= TAG_A;
            core_in   <= '0;
            range_err <= 1'b0;
        end else begin
            if (grant_a)      rr_ptr <= TAG_B;
            else if (grant_b) rr_ptr <= TAG_A;
            core_in <= issue ? issue_coef : '0;
            if (issue && any_out_of_range(issue_coef)) range_err <= 1'b1;
        end
    end

    // Valid/tag shift register following each transform through the core.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trk_vld <= '0;
            trk_tag <= '0;
        end else begin
            trk_vld <= {trk_vld[CORE_LAT-1:0], issue};
            trk_tag <= {trk_tag[CORE_LAT-1:0], grant_b};
        end
    end

    assign push       = trk_vld[CORE_LAT];
    assign push_entry = '{tag: tag_t'(trk_tag[CORE_LAT]), data: core_out};
    assign pop        = !fifo_empty && bus.res_ready;

    ntt_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(result_t))
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Head entry is masked to zero while empty so the idle bus shows reset values.
    assign bus.res_valid = !fifo_empty;
    assign bus.res_tag   = fifo_empty ? 1'b0 : logic'(head.tag);
    assign bus.res_data  = fifo_empty ? '0 : head.data;

    assign busy = (inflight_count != '0) || !fifo_empty;

endmodule

// File: tb/tb_ntt4_core_arbiter.sv
// Directed bench for the shared NTT core arbiter with a behavioural 4-cycle core model.
module tb_ntt4_core_arbiter;
    import ntt_pkg::*;

    logic      clk = 1'b0;
    logic      reset_n;
    coef_vec_t core_in;
    coef_vec_t core_out;
    logic      busy;
    logic      range_err;

    int total = 0;
    int bad   = 0;

    result_t exp_q[$];

    ntt4_core_arbiter_if bus();

    ntt4_core_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .core_in   (core_in),
        .core_out  (core_out),
        .busy      (busy),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    // Reference 4-point negacyclic NTT: X[k] = sum x[j] * psi^(j*(2*bitrev(k)+1)) mod Q.
    function automatic coef_vec_t ntt_model(input coef_vec_t x);
        coef_vec_t y;
        int pw[8];
        int e;
        int acc;
        pw[0] = 1; pw[1] = PSI; pw[2] = OMEGA; pw[3] = PSI3;
        for (int i = 4; i < 8; i++) pw[i] = Q - pw[i-4];
        for (int k = 0; k < 4; k++) begin
            e   = (k == 1) ? 5 : (k == 2) ? 3 : (k == 3) ? 7 : 1;
            acc = 0;
            for (int j = 0; j < 4; j++) acc = (acc + (int'(x[j]) % Q) * pw[(j*e) % 8]) % Q;
            y[k] = coef_t'(acc);
        end
        return y;
    endfunction

    // Free-running core: result appears CORE_LAT cycles after core_in is sampled.
    coef_vec_t core_pipe [4];
    always @(posedge clk) begin
        core_pipe[0] <= core_in;
        for (int i = 1; i < 4; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_out = ntt_model(core_pipe[3]);

    function automatic coef_vec_t mk(input int c0, input int c1, input int c2, input int c3);
        coef_vec_t v;
        v[0] = coef_t'(c0); v[1] = coef_t'(c1); v[2] = coef_t'(c2); v[3] = coef_t'(c3);
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        bus.a_coef  = '0;
        bus.b_coef  = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({bus.a_ready, bus.b_ready, bus.res_valid, bus.res_tag, busy, range_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {bus.a_ready, bus.b_ready, bus.res_valid, bus.res_tag, busy, range_err});
        end
        total++;
        if (bus.res_data !== '0) begin
            bad++; $display("FAIL reset_res_data: got %0h want 0", bus.res_data);
        end
        total++;
        if (core_in !== '0) begin
            bad++; $display("FAIL reset_core_in: got %0h want 0", core_in);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single_a();
        int seen;
        seen = -1;
        bus.a_valid = 1'b1;
        bus.a_coef  = mk(1, 0, 0, 0);
        @(negedge clk);
        total++;
        if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
            bad++; $display("FAIL single_a_grant: got %b want 10", {bus.a_ready, bus.b_ready});
        end
        next_cycle();
        idle_inputs();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1 && seen < 0) begin
                seen = c;
                total++;
                if (bus.res_tag !== 1'b0) begin
                    bad++; $display("FAIL single_a_tag: got %b want 0", bus.res_tag);
                end
                total++;
                if (bus.res_data !== mk(1, 1, 1, 1)) begin
                    bad++; $display("FAIL single_a_data: got %0h want %0h", bus.res_data, mk(1, 1, 1, 1));
                end
            end
            next_cycle();
        end
        total++;
        if (seen != 6) begin
            bad++; $display("FAIL single_a_latency: got %0d want 6", seen);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL single_a_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_single_b();
        int seen;
        seen = -1;
        bus.b_valid = 1'b1;
        bus.b_coef  = mk(0, 1, 0, 0);
        @(negedge clk);
        total++;
        if ({bus.a_ready, bus.b_ready} !== 2'b01) begin
            bad++; $display("FAIL single_b_grant: got %b want 01", {bus.a_ready, bus.b_ready});
        end
        next_cycle();
        idle_inputs();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1 && seen < 0) begin
                seen = c;
                total++;
                if (bus.res_tag !== 1'b1) begin
                    bad++; $display("FAIL single_b_tag: got %b want 1", bus.res_tag);
                end
                total++;
                if (bus.res_data !== mk(1925, 5756, 6468, 1213)) begin
                    bad++;
                    $display("FAIL single_b_data: got %0h want %0h", bus.res_data, mk(1925, 5756, 6468, 1213));
                end
            end
            next_cycle();
        end
        total++;
        if (seen != 6) begin
            bad++; $display("FAIL single_b_latency: got %0d want 6", seen);
        end
    endtask

    task automatic test_back_to_back();
        int first, last, nres;
        result_t e;
        first = -1; last = -1; nres = 0;
        exp_q.delete();
        bus.res_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c < 8) begin
                bus.a_valid = 1'b1; bus.a_coef = mk(10 + c, 20 + c, 30 + c, 40 + c);
                bus.b_valid = 1'b1; bus.b_coef = mk(500 + c, 600 + c, 7000 + c, 3 + c);
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            if (c < 8) begin
                total++;
                if ({bus.a_ready, bus.b_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                    bad++;
                    $display("FAIL b2b_grant[%0d]: got %b want %b", c, {bus.a_ready, bus.b_ready},
                             (c % 2 == 0) ? 2'b10 : 2'b01);
                end
                if (c % 2 == 0) exp_q.push_back('{tag: TAG_A, data: ntt_model(bus.a_coef)});
                else            exp_q.push_back('{tag: TAG_B, data: ntt_model(bus.b_coef)});
            end
            if (bus.res_valid === 1'b1) begin
                nres++;
                if (first < 0) first = c;
                last = c;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra: unexpected result %0h", {bus.res_tag, bus.res_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.res_tag, bus.res_data} !== e) begin
                        bad++; $display("FAIL b2b_result: got %0h want %0h", {bus.res_tag, bus.res_data}, e);
                    end
                end
            end
            next_cycle();
        end
        total++;
        if (nres != 8 || first != 6 || last != 13) begin
            bad++; $display("FAIL b2b_rate: got n=%0d first=%0d last=%0d want n=8 first=6 last=13",
                            nres, first, last);
        end
    endtask

    task automatic test_backpressure();
        int ngrant, ngrant2, nres;
        coef_vec_t held;
        result_t e;
        ngrant = 0; ngrant2 = 0; nres = 0;
        held = '0;
        exp_q.delete();
        bus.res_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.a_valid = 1'b1; bus.a_coef = mk(100 + c, 2 * c, 7 * c, 50);
            bus.b_valid = 1'b1; bus.b_coef = mk(3 * c, 200 + c, 60, 5 * c);
            @(negedge clk);
            if (bus.a_ready === 1'b1) begin
                ngrant++; exp_q.push_back('{tag: TAG_A, data: ntt_model(bus.a_coef)});
            end
            if (bus.b_ready === 1'b1) begin
                ngrant++; exp_q.push_back('{tag: TAG_B, data: ntt_model(bus.b_coef)});
            end
            if (c == 15) held = bus.res_data;
            if (c == 19) begin
                total++;
                if (bus.res_valid !== 1'b1 || bus.res_data !== held) begin
                    bad++; $display("FAIL bp_hold: valid=%b data=%0h want valid=1 data=%0h",
                                    bus.res_valid, bus.res_data, held);
                end
                total++;
                if (busy !== 1'b1) begin
                    bad++; $display("FAIL bp_busy: got %b want 1", busy);
                end
            end
            next_cycle();
        end
        total++;
        if (ngrant != 8) begin
            bad++; $display("FAIL bp_grant_count: got %0d want 8", ngrant);
        end
        bus.res_ready = 1'b1;
        for (int c = 0; c < 45; c++) begin
            if (c < 12) begin
                bus.a_valid = 1'b1; bus.a_coef = mk(900 + c, c, 1, 2);
                bus.b_valid = 1'b1; bus.b_coef = mk(c, 1300 + c, 4, 5);
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            if (c == 0) begin
                total++;
                if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
                    bad++; $display("FAIL bp_full_ready: got %b want 00", {bus.a_ready, bus.b_ready});
                end
            end
            if (bus.a_ready === 1'b1) begin
                ngrant2++; exp_q.push_back('{tag: TAG_A, data: ntt_model(bus.a_coef)});
            end
            if (bus.b_ready === 1'b1) begin
                ngrant2++; exp_q.push_back('{tag: TAG_B, data: ntt_model(bus.b_coef)});
            end
            if (bus.res_valid === 1'b1) begin
                nres++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL bp_extra: unexpected result %0h", {bus.res_tag, bus.res_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.res_tag, bus.res_data} !== e) begin
                        bad++; $display("FAIL bp_result: got %0h want %0h", {bus.res_tag, bus.res_data}, e);
                    end
                end
            end
            next_cycle();
        end
        total++;
        if (ngrant2 == 0 || nres != 8 + ngrant2 || exp_q.size() != 0) begin
            bad++; $display("FAIL bp_drain: got grants=%0d results=%0d left=%0d want results=grants+8 left=0",
                            ngrant2, nres, exp_q.size());
        end
    endtask

    task automatic test_range();
        int seen;
        total++;
        if (range_err !== 1'b0) begin
            bad++; $display("FAIL range_initial: got %b want 0", range_err);
        end
        bus.a_valid = 1'b1;
        bus.a_coef  = mk(7680, 0, 0, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        total++;
        if (range_err !== 1'b0) begin
            bad++; $display("FAIL range_q_minus_1: got %b want 0", range_err);
        end
        seen = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.res_valid === 1'b1 && seen == 0) begin
                seen = 1;
                total++;
                if (bus.res_data !== mk(7680, 7680, 7680, 7680)) begin
                    bad++; $display("FAIL range_q_minus_1_data: got %0h want %0h", bus.res_data,
                                    mk(7680, 7680, 7680, 7680));
                end
            end
            next_cycle();
        end
        bus.a_valid = 1'b1;
        bus.a_coef  = mk(7681, 1, 0, 0);
        @(negedge clk);
        total++;
        if (bus.a_ready !== 1'b1 || range_err !== 1'b0) begin
            bad++; $display("FAIL range_issue: ready=%b err=%b want ready=1 err=0", bus.a_ready, range_err);
        end
        next_cycle();
        idle_inputs();
        seen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++;
                if (range_err !== 1'b1) begin
                    bad++; $display("FAIL range_set: got %b want 1", range_err);
                end
            end
            if (bus.res_valid === 1'b1 && seen == 0) begin
                seen = 1;
                total++;
                if ({bus.res_tag, bus.res_data} !== {1'b0, mk(1925, 5756, 6468, 1213)}) begin
                    bad++; $display("FAIL range_result: got %0h want %0h", {bus.res_tag, bus.res_data},
                                    {1'b0, mk(1925, 5756, 6468, 1213)});
                end
            end
            next_cycle();
        end
        total++;
        if (seen != 1 || range_err !== 1'b1) begin
            bad++; $display("FAIL range_sticky: seen=%0d err=%b want seen=1 err=1", seen, range_err);
        end
    endtask

    task automatic test_reset_midop();
        int stale, seen;
        bus.res_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.a_valid = 1'b1;
            bus.a_coef  = mk(c + 1, c + 2, c + 3, c + 4);
            @(negedge clk);
            next_cycle();
        end
        idle_inputs();
        repeat (2) begin
            @(negedge clk);
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (bus.res_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL midop_state: valid=%b busy=%b want 1 1", bus.res_valid, busy);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.a_ready, bus.b_ready, bus.res_valid, bus.res_tag, busy, range_err} !== 6'b0) begin
            bad++;
            $display("FAIL midop_reset_flags: got %b want 000000",
                     {bus.a_ready, bus.b_ready, bus.res_valid, bus.res_tag, busy, range_err});
        end
        total++;
        if (bus.res_data !== '0 || core_in !== '0) begin
            bad++; $display("FAIL midop_reset_data: res=%0h core=%0h want 0 0", bus.res_data, core_in);
        end
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.res_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0 || busy !== 1'b0) stale++;
            next_cycle();
        end
        total++;
        if (stale != 0) begin
            bad++; $display("FAIL midop_stale: got %0d stale cycles want 0", stale);
        end
        bus.a_valid = 1'b1; bus.a_coef = mk(2, 0, 0, 0);
        bus.b_valid = 1'b1; bus.b_coef = mk(0, 0, 0, 3);
        @(negedge clk);
        total++;
        if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
            bad++; $display("FAIL midop_rr_reset: got %b want 10", {bus.a_ready, bus.b_ready});
        end
        next_cycle();
        idle_inputs();
        seen = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1 && seen < 0) begin
                seen = c;
                total++;
                if ({bus.res_tag, bus.res_data} !== {1'b0, mk(2, 2, 2, 2)}) begin
                    bad++; $display("FAIL midop_result: got %0h want %0h", {bus.res_tag, bus.res_data},
                                    {1'b0, mk(2, 2, 2, 2)});
                end
            end
            next_cycle();
        end
        total++;
        if (seen != 6) begin
            bad++; $display("FAIL midop_latency: got %0d want 6", seen);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.res_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_single_a();
        test_single_b();
        test_back_to_back();
        test_backpressure();
        test_range();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
